// File: rtl/dmem_responder_pkg.sv
// Shared encodings and defaults for the data-memory responder.
package dmem_pkg;
   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      OP_RD  = 2'd0,
      OP_WR  = 2'd1,
      OP_BAD = 2'd2
   } op_e;

   // Both strobes or an out-of-range address make the request unserviceable.
   function automatic op_e decode_op(input logic rd, input logic wr, input logic bad_addr);
      if ((rd && wr) || bad_addr) return OP_BAD;
      else if (wr)                return OP_WR;
      else                        return OP_RD;
   endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// Processor-side request/response bundle of the data-memory responder.
interface dmem_responder_if #(
   parameter int DATA_W = 8
);
   logic              ReadDMem;
   logic              WriteDMem;
   logic [7:0]        address;
   logic [DATA_W-1:0] writeData;
   logic [DATA_W-1:0] readData;
   logic              ready;
   logic              busy;
   logic              error;

   modport master (
      output ReadDMem, WriteDMem, address, writeData,
      input  readData, ready, busy, error
   );

   modport slave (
      input  ReadDMem, WriteDMem, address, writeData,
      output readData, ready, busy, error
   );
endinterface

// File: rtl/dmem_responder_array.sv
// DEPTH x DATA_W register file: one synchronous write port, one combinational read port.
module dmem_array #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              we_i,
   input  logic [ADDR_W-1:0]                 idx_i,
   input  logic [DATA_W-1:0]                 wdata_i,
   output logic [DATA_W-1:0]                 rdata_o,
   output logic [(2**ADDR_W)*DATA_W-1:0]     DMdata
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0][DATA_W-1:0] mem_q;

   always_ff @(posedge clk) begin
      if (rst)       mem_q        <= '0;
      else if (we_i) mem_q[idx_i] <= wdata_i;
   end

   assign rdata_o = mem_q[idx_i];
   assign DMdata  = mem_q;
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: IDLE/WAIT/RESP handshake with programmable wait states.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   dmem_responder_if.slave               bus,
   output logic [(2**ADDR_W)*DATA_W-1:0] DMdata
);
   state_e            state_q;
   op_e               op_q;
   logic [3:0]        cnt_q;
   logic [7:0]        addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              ready_q, busy_q, error_q;

   logic              req, commit, we;
   logic [7:0]        addr_hi;
   op_e               in_op, c_op;
   logic [7:0]        c_addr;
   logic [DATA_W-1:0] c_wdata, rd_word;

   assign req     = bus.ReadDMem | bus.WriteDMem;
   assign addr_hi = bus.address >> ADDR_W;
   assign in_op   = decode_op(bus.ReadDMem, bus.WriteDMem, addr_hi != 8'd0);

   // With zero wait states the commit happens on the accept edge, straight from the bus.
   always_comb begin
      commit  = 1'b0;
      c_op    = op_q;
      c_addr  = addr_q;
      c_wdata = wdata_q;
      if (state_q == IDLE && req && WAIT_CYCLES == 0) begin
         commit  = 1'b1;
         c_op    = in_op;
         c_addr  = bus.address;
         c_wdata = bus.writeData;
      end else if (state_q == WAIT && cnt_q == 4'd0) begin
         commit = 1'b1;
      end
   end

   assign we = commit && (c_op == OP_WR);

   dmem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
      .clk     (clk),
      .rst     (rst),
      .we_i    (we),
      .idx_i   (c_addr[ADDR_W-1:0]),
      .wdata_i (c_wdata),
      .rdata_o (rd_word),
      .DMdata  (DMdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= OP_RD;
         cnt_q   <= 4'd0;
         addr_q  <= 8'd0;
         wdata_q <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         error_q <= 1'b0;
         case (state_q)
            IDLE: if (req) begin
               op_q    <= in_op;
               addr_q  <= bus.address;
               wdata_q <= bus.writeData;
               busy_q  <= 1'b1;
               if (WAIT_CYCLES == 0) state_q <= RESP;
               else begin
                  state_q <= WAIT;
                  cnt_q   <= 4'(WAIT_CYCLES - 1);
               end
            end
            WAIT: begin
               if (cnt_q == 4'd0) state_q <= RESP;
               else               cnt_q   <= cnt_q - 4'd1;
            end
            RESP: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
         if (commit) begin
            ready_q <= 1'b1;
            error_q <= (c_op == OP_BAD);
            if (c_op == OP_BAD)     rdata_q <= '0;
            else if (c_op == OP_RD) rdata_q <= rd_word;
         end
      end
   end

   assign bus.readData = rdata_q;
   assign bus.ready    = ready_q;
   assign bus.busy     = busy_q;
   assign bus.error    = error_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench: two responders (2 and 0 wait states) checked against a transaction-level model.
module tb_dmem_responder;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] dm0, dm1;

   always #5 clk = ~clk;

   dmem_responder_if #(.DATA_W(8)) if0 ();
   dmem_responder_if #(.DATA_W(8)) if1 ();

   dmem_responder #(.DATA_W(8), .ADDR_W(3), .WAIT_CYCLES(2)) u0 (
      .clk(clk), .rst(rst), .bus(if0), .DMdata(dm0));
   dmem_responder #(.DATA_W(8), .ADDR_W(3), .WAIT_CYCLES(0)) u1 (
      .clk(clk), .rst(rst), .bus(if1), .DMdata(dm1));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Transaction model: a request accepted from idle completes lat[d] edges later,
   // shows ready for one cycle, then the responder is idle again.
   int         lat [2] = '{2, 0};
   bit         m_infl [2], m_rd [2], m_wr [2], m_ready [2], m_err [2];
   int         m_rem [2];
   logic [7:0] m_a [2], m_d [2], m_rdata [2];
   logic [7:0] m_mem [2][8];
   bit         chk_en = 0;

   task automatic mfinish(input int d);
      bit bad;
      bad = (m_rd[d] && m_wr[d]) || (m_a[d] >= 8'd8);
      m_ready[d] = 1;
      m_err[d]   = bad;
      if (bad)          m_rdata[d] = 8'h00;
      else if (m_rd[d]) m_rdata[d] = m_mem[d][m_a[d][2:0]];
      else              m_mem[d][m_a[d][2:0]] = m_d[d];
   endtask

   task automatic mstep(input int d, input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] wd);
      if (m_ready[d]) begin
         m_ready[d] = 0; m_err[d] = 0; m_infl[d] = 0;
      end else if (!m_infl[d]) begin
         if (rd || wr) begin
            m_infl[d] = 1; m_rd[d] = rd; m_wr[d] = wr; m_a[d] = a; m_d[d] = wd;
            m_rem[d] = lat[d];
            if (m_rem[d] == 0) mfinish(d);
         end
      end else begin
         m_rem[d]--;
         if (m_rem[d] == 0) mfinish(d);
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         chk_en = 1;
         for (int d = 0; d < 2; d++) begin
            m_infl[d] = 0; m_ready[d] = 0; m_err[d] = 0; m_rdata[d] = 8'h00; m_rem[d] = 0;
            for (int i = 0; i < 8; i++) m_mem[d][i] = 8'h00;
         end
      end else begin
         mstep(0, if0.ReadDMem, if0.WriteDMem, if0.address, if0.writeData);
         mstep(1, if1.ReadDMem, if1.WriteDMem, if1.address, if1.writeData);
      end
   end

   task automatic cmp_dut(input int d, input logic r, input logic b, input logic e,
                          input logic [7:0] rdv, input logic [63:0] dm);
      logic [63:0] exp_dm;
      for (int i = 0; i < 8; i++) exp_dm[i*8 +: 8] = m_mem[d][i];
      chk($sformatf("u%0d ready", d),    {63'd0, r}, {63'd0, m_ready[d]});
      chk($sformatf("u%0d busy", d),     {63'd0, b}, {63'd0, m_infl[d]});
      chk($sformatf("u%0d error", d),    {63'd0, e}, {63'd0, m_err[d]});
      chk($sformatf("u%0d readData", d), {56'd0, rdv}, {56'd0, m_rdata[d]});
      chk($sformatf("u%0d DMdata", d),   dm, exp_dm);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp_dut(0, if0.ready, if0.busy, if0.error, if0.readData, dm0);
         cmp_dut(1, if1.ready, if1.busy, if1.error, if1.readData, dm1);
      end
   end

   // Drive one request on u0, hold it until ready is seen; lat_o is the negedge index of ready.
   task automatic req0(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                       input bit tog, output int lat_o);
      lat_o = -1;
      @(negedge clk);
      if0.ReadDMem = rd; if0.WriteDMem = wr; if0.address = a; if0.writeData = wd;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tog && i == 0) begin
            if0.ReadDMem = 1'b1; if0.WriteDMem = 1'b0; if0.address = a ^ 8'h07; if0.writeData = ~wd;
         end
         if (if0.ready) begin
            lat_o = i;
            break;
         end
      end
      if0.ReadDMem = 1'b0; if0.WriteDMem = 1'b0;
      chk("req0 ready seen", {63'd0, lat_o >= 0}, 64'd1);
   endtask

   initial begin
      int l;
      bit saw_ready;
      if0.ReadDMem = 0; if0.WriteDMem = 0; if0.address = 0; if0.writeData = 0;
      if1.ReadDMem = 0; if1.WriteDMem = 0; if1.address = 0; if1.writeData = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset readData", {56'd0, if0.readData}, 64'd0);
      chk("reset ready",    {63'd0, if0.ready}, 64'd0);
      chk("reset busy",     {63'd0, if0.busy}, 64'd0);
      chk("reset DMdata",   dm0, 64'h0);

      req0(0, 1, 8'd3, 8'hA5, 0, l);
      chk("write latency", l, 2);
      chk("write word3", {56'd0, dm0[31:24]}, 64'hA5);
      req0(1, 0, 8'd3, 8'h00, 0, l);
      chk("read word3", {56'd0, if0.readData}, 64'hA5);
      chk("read word3 error", {63'd0, if0.error}, 64'd0);

      req0(1, 1, 8'd1, 8'h77, 0, l);
      chk("both strobes error", {63'd0, if0.error}, 64'd1);
      chk("both strobes readData", {56'd0, if0.readData}, 64'd0);
      chk("both strobes word1", {56'd0, dm0[15:8]}, 64'd0);
      req0(1, 0, 8'h09, 8'h00, 0, l);
      chk("addr 9 error", {63'd0, if0.error}, 64'd1);
      chk("addr 9 word1", {56'd0, dm0[15:8]}, 64'd0);

      // Strobes changed in WAIT must not affect the latched write to word 2.
      req0(0, 1, 8'd2, 8'hC3, 1, l);
      chk("toggle latency", l, 2);
      chk("toggle word2", {56'd0, dm0[23:16]}, 64'hC3);
      chk("toggle word5", {56'd0, dm0[47:40]}, 64'd0);
      chk("toggle error", {63'd0, if0.error}, 64'd0);
      req0(1, 0, 8'd2, 8'h00, 0, l);
      chk("read word2", {56'd0, if0.readData}, 64'hC3);

      // Reset in WAIT aborts the write to word 7.
      @(negedge clk);
      if0.WriteDMem = 1; if0.address = 8'd7; if0.writeData = 8'h3C;
      @(negedge clk);
      rst = 1'b1; if0.WriteDMem = 0;
      @(negedge clk);
      rst = 1'b0;
      saw_ready = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (if0.ready) saw_ready = 1;
      end
      chk("rst abort ready", {63'd0, saw_ready}, 64'd0);
      chk("rst abort busy", {63'd0, if0.busy}, 64'd0);
      chk("rst abort word7", {56'd0, dm0[63:56]}, 64'd0);
      req0(0, 1, 8'd7, 8'h3C, 0, l);
      chk("after rst latency", l, 2);
      chk("after rst word7", {56'd0, dm0[63:56]}, 64'h3C);

      // Zero wait states: held read alternates RESP/IDLE.
      @(negedge clk);
      if1.WriteDMem = 1; if1.address = 8'd3; if1.writeData = 8'h96;
      @(negedge clk);
      chk("u1 write ready", {63'd0, if1.ready}, 64'd1);
      if1.WriteDMem = 0;
      @(negedge clk);
      if1.ReadDMem = 1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("u1 held ready %0d", i), {63'd0, if1.ready}, {63'd0, (i % 2) == 0});
         chk($sformatf("u1 held busy %0d", i),  {63'd0, if1.busy},  {63'd0, (i % 2) == 0});
         if (i % 2 == 0) chk("u1 held readData", {56'd0, if1.readData}, 64'h96);
      end
      if1.ReadDMem = 0;

      // Random traffic on both responders, with occasional reset.
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 99) == 0);
         if0.ReadDMem  = ($urandom_range(0, 2) == 0);
         if0.WriteDMem = ($urandom_range(0, 2) == 0);
         if0.address   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
         if0.writeData = 8'($urandom);
         if1.ReadDMem  = ($urandom_range(0, 2) == 0);
         if1.WriteDMem = ($urandom_range(0, 2) == 0);
         if1.address   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
         if1.writeData = 8'($urandom);
      end
      @(negedge clk);
      rst = 0;
      if0.ReadDMem = 0; if0.WriteDMem = 0; if1.ReadDMem = 0; if1.WriteDMem = 0;
      repeat (6) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
